// File: rtl/biu_constants_pkg.sv
// Shared bus-interface constants: transfer size encoding used by the core buses.
package biu_constants_pkg;

    typedef enum logic [2:0] {
        BYTE  = 3'b000,
        HWORD = 3'b001,
        WORD  = 3'b010,
        DWORD = 3'b011,
        QWORD = 3'b100
    } biu_size_t;

endpackage

// File: rtl/riscv_dmem_resp_pkg.sv
// Types and helpers for the data-memory responder: completion class,
// byte-enable generation, write-lane replication and byte parity.
package riscv_dmem_resp_pkg;
    import biu_constants_pkg::*;

    localparam int unsigned BE_W = 4;

    typedef enum logic [1:0] {
        RESP_OK,
        RESP_ERR,
        RESP_MISALIGNED
    } resp_class_t;

    // Byte enables of an aligned store; illegal sizes never reach the SRAM.
    function automatic logic [BE_W-1:0] be_gen(biu_size_t size, logic [1:0] adr);
        logic [BE_W-1:0] be;
        case (size)
            BYTE:    be = 4'b0001 << adr;
            HWORD:   be = 4'b0011 << adr;
            WORD:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Right-justified store data replicated across the word so that whichever
    // lane the byte enables select carries the payload.
    function automatic logic [31:0] lane_shift(logic [31:0] data, biu_size_t size);
        logic [31:0] d;
        case (size)
            BYTE:    d = {4{data[7:0]}};
            HWORD:   d = {2{data[15:0]}};
            default: d = data;
        endcase
        return d;
    endfunction

    // Even parity per byte: the parity bit makes the 9-bit group's popcount even.
    function automatic logic [BE_W-1:0] even_par(logic [31:0] data);
        logic [BE_W-1:0] p;
        for (int b = 0; b < BE_W; b++) p[b] = ^data[8*b +: 8];
        return p;
    endfunction

endpackage

// File: rtl/riscv_dmem_resp_if.sv
// Core data-memory bus. The core is the master, riscv_dmem_resp the slave.
interface riscv_dmem_resp_if #(
    parameter int XLEN = 32
);
    import biu_constants_pkg::*;

    logic            req;
    logic [XLEN-1:0] adr;
    logic [XLEN-1:0] d;
    logic            we;
    biu_size_t       size;
    logic            ack;
    logic [XLEN-1:0] q;
    logic            err;
    logic            misaligned;
    logic            page_fault;

    modport master (
        output req, adr, d, we, size,
        input  ack, q, err, misaligned, page_fault
    );

    modport slave (
        input  req, adr, d, we, size,
        output ack, q, err, misaligned, page_fault
    );

endinterface

// File: rtl/riscv_dmem_resp_pipe.sv
// In-order completion pipeline: carries valid, class and we of every accepted
// request for DEPTH cycles so completions emerge at a fixed latency.
module riscv_dmem_resp_pipe
    import riscv_dmem_resp_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        i_vld,
    input  resp_class_t i_cls,
    input  logic        i_we,
    output logic        o_vld,
    output resp_class_t o_cls,
    output logic        o_we,
    output logic        o_busy
);

    logic [DEPTH:1] r_vld_pipe;
    resp_class_t    r_cls_pipe [DEPTH:1];
    logic [DEPTH:1] r_we_pipe;

    // Shift one stage per cycle; reset drops everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_pipe <= '0;
            r_we_pipe  <= '0;
            for (int s = 1; s <= DEPTH; s++) r_cls_pipe[s] <= RESP_OK;
        end else begin
            r_vld_pipe[1] <= i_vld;
            r_cls_pipe[1] <= i_cls;
            r_we_pipe[1]  <= i_we;
            for (int s = 2; s <= DEPTH; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1];
                r_cls_pipe[s] <= r_cls_pipe[s-1];
                r_we_pipe[s]  <= r_we_pipe[s-1];
            end
        end
    end

    assign o_vld  = r_vld_pipe[DEPTH];
    assign o_cls  = r_cls_pipe[DEPTH];
    assign o_we   = r_we_pipe[DEPTH];
    assign o_busy = |r_vld_pipe;

endmodule

// File: rtl/riscv_dmem_resp.sv
// Data-memory responder between the core dmem bus and a single-port
// synchronous SRAM. Classifies each request (misaligned / out of range / ok),
// issues a registered SRAM command for legal ones and completes every request
// exactly 1+RD_LATENCY cycles after it was presented, in order.
// Optional: define RISCV_DMEM_RESP_PARITY_EN for per-byte even parity on the
// SRAM side; a parity mismatch on a load turns the ack into an error.
module riscv_dmem_resp
    import biu_constants_pkg::*;
    import riscv_dmem_resp_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] MEM_BASE   = 'h0,
    parameter int unsigned     MEM_SIZE   = 'h10000,
    parameter int              RD_LATENCY = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    riscv_dmem_resp_if.slave                dmem,
    output logic                            sram_ce_o,
    output logic                            sram_we_o,
    output logic [XLEN/8-1:0]               sram_be_o,
    output logic [$clog2(MEM_SIZE)-3:0]     sram_addr_o,
    output logic [XLEN-1:0]                 sram_d_o,
    input  logic [XLEN-1:0]                 sram_q_i,
    output logic [XLEN/8-1:0]               sram_par_o,
    input  logic [XLEN/8-1:0]               sram_par_i,
    output logic                            busy_o
);

    localparam int AW = $clog2(MEM_SIZE) - 2;

    logic [XLEN-1:0]   w_off;
    logic              w_mis;
    logic              w_oor;
    resp_class_t       w_cls;
    logic              w_legal;
    logic [XLEN/8-1:0] w_be;
    logic [XLEN-1:0]   w_wdata;
    logic [XLEN/8-1:0] w_par;

    logic              w_cvld;
    resp_class_t       w_ccls;
    logic              w_cwe;
    logic              w_par_err;

    logic              r_ce;
    logic              r_we;
    logic [XLEN/8-1:0] r_be;
    logic [AW-1:0]     r_addr;
    logic [XLEN-1:0]   r_d;
    logic [XLEN/8-1:0] r_par;

    // Offset wraps for addresses below MEM_BASE, so a single unsigned compare
    // covers both sides of the window.
    assign w_off = dmem.adr - MEM_BASE;
    assign w_oor = w_off >= XLEN'(MEM_SIZE);

    // Alignment check; DWORD can never be naturally aligned on a 32-bit bus.
    always_comb begin
        w_mis = 1'b1;
        case (dmem.size)
            BYTE:    w_mis = 1'b0;
            HWORD:   w_mis = dmem.adr[0];
            WORD:    w_mis = |dmem.adr[1:0];
            default: w_mis = 1'b1;
        endcase
    end

    // Misalignment wins over a range error.
    always_comb begin
        w_cls = RESP_OK;
        if (w_mis)      w_cls = RESP_MISALIGNED;
        else if (w_oor) w_cls = RESP_ERR;
    end

    assign w_legal = dmem.req && (w_cls == RESP_OK);
    assign w_be    = dmem.we ? be_gen(dmem.size, dmem.adr[1:0]) : '1;
    assign w_wdata = lane_shift(dmem.d, dmem.size);

`ifdef RISCV_DMEM_RESP_PARITY_EN
    assign w_par = even_par(w_wdata);
`else
    assign w_par = '0;
`endif

    // Registered SRAM command; idle cycles and illegal requests leave it all zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ce   <= 1'b0;
            r_we   <= 1'b0;
            r_be   <= '0;
            r_addr <= '0;
            r_d    <= '0;
            r_par  <= '0;
        end else begin
            r_ce   <= w_legal;
            r_we   <= w_legal && dmem.we;
            r_be   <= w_legal ? w_be : '0;
            r_addr <= w_legal ? w_off[AW+1:2] : '0;
            r_d    <= w_legal ? w_wdata : '0;
            r_par  <= (w_legal && dmem.we) ? w_par : '0;
        end
    end

    assign sram_ce_o   = r_ce;
    assign sram_we_o   = r_we;
    assign sram_be_o   = r_be;
    assign sram_addr_o = r_addr;
    assign sram_d_o    = r_d;
    assign sram_par_o  = r_par;

    // One stage for the command register plus the SRAM read latency.
    riscv_dmem_resp_pipe #(
        .DEPTH (1 + RD_LATENCY)
    ) u_pipe (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_vld  (dmem.req),
        .i_cls  (w_cls),
        .i_we   (dmem.we),
        .o_vld  (w_cvld),
        .o_cls  (w_ccls),
        .o_we   (w_cwe),
        .o_busy (busy_o)
    );

`ifdef RISCV_DMEM_RESP_PARITY_EN
    assign w_par_err = w_cvld && (w_ccls == RESP_OK) && !w_cwe &&
                       (even_par(sram_q_i) != sram_par_i);
`else
    logic w_unused_par;
    assign w_unused_par = ^sram_par_i;
    assign w_par_err    = 1'b0;
`endif

    assign dmem.ack        = w_cvld && (w_ccls == RESP_OK) && !w_par_err;
    assign dmem.err        = w_cvld && ((w_ccls == RESP_ERR) || w_par_err);
    assign dmem.misaligned = w_cvld && (w_ccls == RESP_MISALIGNED);
    assign dmem.page_fault = 1'b0;
    assign dmem.q          = (dmem.ack && !w_cwe) ? sram_q_i : '0;

endmodule

// File: tb/tb_riscv_dmem_resp.sv
// Directed bench for riscv_dmem_resp: one instance with RD_LATENCY=1 backed by
// a behavioural SRAM, one with RD_LATENCY=3 for back-to-back and reset cases.
module tb_riscv_dmem_resp;
    import biu_constants_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    riscv_dmem_resp_if #(.XLEN(32)) dm1 ();
    riscv_dmem_resp_if #(.XLEN(32)) dm3 ();

    logic        ce1, we1, busy1, ce3, we3, busy3;
    logic [3:0]  be1, be3, pout1, pout3, pin1;
    logic [13:0] addr1, addr3;
    logic [31:0] d1, d3, q1;
    logic [3:0]  p1;
    logic        par_flip = 1'b0;

    riscv_dmem_resp #(.XLEN(32), .MEM_BASE(32'h0), .MEM_SIZE(32'h10000), .RD_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .dmem(dm1),
        .sram_ce_o(ce1), .sram_we_o(we1), .sram_be_o(be1), .sram_addr_o(addr1),
        .sram_d_o(d1), .sram_q_i(q1), .sram_par_o(pout1), .sram_par_i(pin1),
        .busy_o(busy1)
    );

    riscv_dmem_resp #(.XLEN(32), .MEM_BASE(32'h0), .MEM_SIZE(32'h10000), .RD_LATENCY(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .dmem(dm3),
        .sram_ce_o(ce3), .sram_we_o(we3), .sram_be_o(be3), .sram_addr_o(addr3),
        .sram_d_o(d3), .sram_q_i(32'h0), .sram_par_o(pout3), .sram_par_i(4'h0),
        .busy_o(busy3)
    );

    // Behavioural 1-cycle SRAM with a parity side array.
    logic [31:0] mem  [0:16383];
    logic [3:0]  mpar [0:16383];
    initial for (int i = 0; i < 16384; i++) begin mem[i] = '0; mpar[i] = '0; end
    always @(posedge clk) begin
        if (ce1) begin
            if (we1) begin
                for (int b = 0; b < 4; b++)
                    if (be1[b]) begin
                        mem[addr1][8*b +: 8] <= d1[8*b +: 8];
                        mpar[addr1][b]       <= pout1[b];
                    end
            end else begin
                q1 <= mem[addr1];
                p1 <= mpar[addr1];
            end
        end
    end
    assign pin1 = p1 ^ (par_flip ? 4'b0100 : 4'b0000);

`ifdef RISCV_DMEM_RESP_PARITY_EN
    localparam logic [3:0]  EXP_PAR   = 4'b1101;
    localparam logic [2:0]  EXP_FLIP  = 3'b010;
    localparam logic [31:0] EXP_FLIPQ = 32'h0;
`else
    localparam logic [3:0]  EXP_PAR   = 4'b0000;
    localparam logic [2:0]  EXP_FLIP  = 3'b100;
    localparam logic [31:0] EXP_FLIPQ = 32'h01020307;
`endif

    // Back-to-back vectors: expected {ack,err,misaligned}.
    logic [31:0] a3 [8] = '{32'h0, 32'h3, 32'h10000, 32'h5, 32'h8, 32'h10002, 32'hFFFFFFFC, 32'h2};
    biu_size_t   s3 [8] = '{WORD, HWORD, WORD, BYTE, DWORD, WORD, WORD, HWORD};
    logic        w3 [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0]  e3 [8] = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001, 3'b001, 3'b010, 3'b100};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h exp %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int unit, input logic we, input biu_size_t sz,
                         input logic [31:0] adr, input logic [31:0] d);
        if (unit == 1) begin
            dm1.req = 1'b1; dm1.we = we; dm1.size = sz; dm1.adr = adr; dm1.d = d;
        end else begin
            dm3.req = 1'b1; dm3.we = we; dm3.size = sz; dm3.adr = adr; dm3.d = d;
        end
    endtask

    task automatic idle(input int unit);
        if (unit == 1) dm1.req = 1'b0;
        else           dm3.req = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        dm1.req = 0; dm1.we = 0; dm1.size = WORD; dm1.adr = '0; dm1.d = '0;
        dm3.req = 0; dm3.we = 0; dm3.size = WORD; dm3.adr = '0; dm3.d = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_out1", {dm1.ack, dm1.err, dm1.misaligned, dm1.page_fault, ce1, we1, busy1}, 0);
        check("rst_q1", dm1.q, 0);
        check("rst_bus1", {be1, addr1, pout1}, 0);
        check("rst_out3", {dm3.ack, dm3.err, dm3.misaligned, dm3.page_fault, ce3, we3, busy3}, 0);

        // WORD store then WORD load
        issue(1, 1'b1, WORD, 32'h10, 32'hDEADBEEF); step();
        check("st_cmd", {ce1, we1, be1}, {2'b11, 4'hF});
        check("st_addr", addr1, 4);
        check("st_data", d1, 32'hDEADBEEF);
        check("st_early", {dm1.ack, dm1.err, dm1.misaligned}, 0);
        issue(1, 1'b0, WORD, 32'h10, 32'h0); step();
        check("st_ack", {dm1.ack, dm1.err, dm1.misaligned}, 3'b100);
        check("ld_cmd", {ce1, we1, be1}, {2'b10, 4'hF});
        idle(1); step();
        check("ld_ack", {dm1.ack, dm1.err, dm1.misaligned}, 3'b100);
        check("ld_q", dm1.q, 32'hDEADBEEF);
        step();
        check("ld_done", {dm1.ack, dm1.err, dm1.misaligned, busy1}, 0);

        // BYTE and HWORD stores into fresh words, then read back
        issue(1, 1'b1, BYTE, 32'h23, 32'h000000A5); step();
        check("sb_be", be1, 4'b1000);
        check("sb_d", d1, 32'hA5A5A5A5);
        check("sb_addr", addr1, 8);
        issue(1, 1'b1, HWORD, 32'h26, 32'h00001234); step();
        check("sh_be", be1, 4'b1100);
        check("sh_d", d1, 32'h12341234);
        check("sb_ack", {dm1.ack, dm1.err, dm1.misaligned}, 3'b100);
        issue(1, 1'b0, WORD, 32'h20, 32'h0); step();
        issue(1, 1'b0, WORD, 32'h24, 32'h0); step();
        check("lb_q", dm1.q, 32'hA5000000);
        idle(1); step();
        check("lh_q", dm1.q, 32'h12340000);

        // Misaligned and out-of-range
        issue(1, 1'b0, HWORD, 32'h1, 32'h0); step(); idle(1);
        check("mis_noce", ce1, 0);
        step();
        check("mis_cls", {dm1.ack, dm1.err, dm1.misaligned}, 3'b001);
        check("mis_q", dm1.q, 0);
        issue(1, 1'b0, WORD, 32'h10000, 32'h0); step(); idle(1);
        check("oor_noce", ce1, 0);
        step();
        check("oor_cls", {dm1.ack, dm1.err, dm1.misaligned}, 3'b010);
        check("oor_q", dm1.q, 0);

        // Eight back-to-back requests, RD_LATENCY=3
        for (int k = 0; k < 12; k++) begin
            if (k < 8) issue(3, w3[k], s3[k], a3[k], 32'h55AA0000 + k);
            else       idle(3);
            if (k >= 4) check("b2b_cls", {dm3.ack, dm3.err, dm3.misaligned}, e3[k-4]);
            else        check("b2b_pre", {dm3.ack, dm3.err, dm3.misaligned}, 0);
            if (k >= 1 && k <= 8) check("b2b_ce", ce3, e3[k-1] == 3'b100);
            if (k == 11) check("b2b_busy", busy3, 1);
            step();
        end
        check("b2b_idle", {busy3, dm3.ack, dm3.err, dm3.misaligned}, 0);

        // Reset with two requests in flight
        issue(3, 1'b0, WORD, 32'h0, 32'h0); step();
        issue(3, 1'b1, WORD, 32'h4, 32'h11111111); step();
        idle(3); rst = 1'b1; step(); rst = 1'b0;
        check("rst_fl_out", {dm3.ack, dm3.err, dm3.misaligned, dm3.page_fault, ce3, we3, busy3}, 0);
        check("rst_fl_bus", {be3, addr3, d3[17:0]}, 0);
        check("rst_fl_q", dm3.q, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            check("rst_drop", {dm3.ack, dm3.err, dm3.misaligned, busy3}, 0);
        end
        issue(3, 1'b0, WORD, 32'h8, 32'h0); step(); idle(3);
        check("post_rst_ce", ce3, 1);
        step(); step();
        check("post_rst_pre", {dm3.ack, dm3.err, dm3.misaligned}, 0);
        step();
        check("post_rst_ack", {dm3.ack, dm3.err, dm3.misaligned}, 3'b100);

        // Parity: generation on store, corrupted parity on load
        issue(1, 1'b1, WORD, 32'h30, 32'h01020307); step(); idle(1);
        check("par_out", pout1, EXP_PAR);
        step(); step();
        issue(1, 1'b0, WORD, 32'h30, 32'h0); step(); idle(1);
        par_flip = 1'b1;
        step();
        check("par_flip_cls", {dm1.ack, dm1.err, dm1.misaligned}, EXP_FLIP);
        check("par_flip_q", dm1.q, EXP_FLIPQ);
        par_flip = 1'b0;
        issue(1, 1'b0, WORD, 32'h30, 32'h0); step(); idle(1);
        step();
        check("par_ok_cls", {dm1.ack, dm1.err, dm1.misaligned}, 3'b100);
        check("par_ok_q", dm1.q, 32'h01020307);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
